// File: rtl/pc_fetch_seq.sv
// Instruction fetch sequencer: drives one instruction-memory read at a time and
// holds the returned word for IF/ID; ID-stage redirects retarget the following fetch.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_pc_r;
    logic        pend_valid_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_r;
    logic        im_req_r;
    logic        if_valid_r;
    logic        addr_err_r;

    logic        redir_take_s;
    logic        redir_bad_s;
    logic [31:0] redir_tgt_s;
    logic [31:0] seq_pc_s;

    function automatic logic [31:0] word_align(input logic [29:0] word);
        return {word, 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // Redirect qualification and next-address candidates
    always_comb begin
        redir_take_s = redirect && (state_r != IDLE);
        redir_bad_s  = redir_take_s && is_misaligned(redirect_pc[1:0]);
        redir_tgt_s  = word_align(redirect_pc[31:2]);
        seq_pc_s     = pc_r + 32'd4;
    end

    // Fetch FSM, pc/pending-target bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            pc_r         <= word_align(RESET_PC[31:2]);
            pend_pc_r    <= 32'h0000_0000;
            pend_valid_r <= 1'b0;
            if_instr_r   <= 32'h0000_0000;
            if_pc_r      <= 32'h0000_0000;
            im_req_r     <= 1'b0;
            if_valid_r   <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            if (redir_bad_s) begin
                addr_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    state_r    <= FETCH;
                    im_req_r   <= 1'b1;
                    if_valid_r <= 1'b0;
                end
                FETCH: begin
                    if (im_ack) begin
                        state_r    <= HOLD;
                        im_req_r   <= 1'b0;
                        if_valid_r <= 1'b1;
                        if_instr_r <= im_rdata;
                        if_pc_r    <= pc_r;
                        // A same-cycle redirect outranks an older pending target
                        if (redir_take_s) begin
                            pc_r         <= redir_tgt_s;
                            pend_valid_r <= 1'b0;
                        end else if (pend_valid_r) begin
                            pc_r         <= pend_pc_r;
                            pend_valid_r <= 1'b0;
                        end else begin
                            pc_r <= seq_pc_s;
                        end
                    end else if (redir_take_s) begin
                        pend_valid_r <= 1'b1;
                        pend_pc_r    <= redir_tgt_s;
                    end
                end
                HOLD: begin
                    if (redir_take_s) begin
                        pend_valid_r <= 1'b1;
                        pend_pc_r    <= redir_tgt_s;
                    end
                    if (if_ready) begin
                        state_r    <= FETCH;
                        im_req_r   <= 1'b1;
                        if_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    im_req_r   <= 1'b0;
                    if_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign im_req   = im_req_r;
    assign im_addr  = pc_r;
    assign pc       = pc_r;
    assign if_valid = if_valid_r;
    assign if_instr = if_instr_r;
    assign if_pc    = if_pc_r;
    assign addr_err = addr_err_r;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: hand-computed fetch addresses, holds,
// redirects, misalignment flag, reset abandonment and address wrap.
module tb_pc_fetch_seq;

    logic        clk;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
    logic        addr_err;

    int vectors = 0;
    int miscompares = 0;

    pc_fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_ready(if_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .pc(pc), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH at 0x3000 with im_ack=0, redirect=0, if_ready=1
    task automatic do_reset();
        reset = 1'b0; im_ack = 1'b0; redirect = 1'b0; if_ready = 1'b1;
        redirect_pc = 32'h0; im_rdata = 32'h0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; im_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3102;
        if_ready = 1'b1; im_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        vectors++;
        if ({im_req, if_valid, addr_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000", {im_req, if_valid, addr_err});
        end
        vectors++;
        if ({pc, im_addr} !== {32'h0000_3000, 32'h0000_3000}) begin
            miscompares++;
            $display("FAIL reset_pc: got pc=%h im_addr=%h want 3000", pc, im_addr);
        end
        vectors++;
        if ({if_instr, if_pc} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_if: got instr=%h pc=%h want 0", if_instr, if_pc);
        end
        redirect = 1'b0; im_ack = 1'b0; reset = 1'b1;
        tick();
        vectors++;
        if ({im_req, if_valid, im_addr} !== {2'b10, 32'h0000_3000}) begin
            miscompares++;
            $display("FAIL idle_to_fetch: got req=%b valid=%b addr=%h want 1 0 3000",
                     im_req, if_valid, im_addr);
        end
    endtask

    task automatic test_idle_redirect();
        reset = 1'b0; tick();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3702;
        tick();
        redirect = 1'b0; im_ack = 1'b1; im_rdata = 32'h1111_0000;
        tick();
        vectors++;
        if ({pc, addr_err} !== {32'h0000_3004, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_redirect_ignored: got pc=%h err=%b want 3004 0", pc, addr_err);
        end
        im_ack = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0000_3000}) begin
            miscompares++;
            $display("FAIL no_ack_stable: got req=%b addr=%h want 1 3000", im_req, im_addr);
        end
        im_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({im_req, if_valid, im_addr} !== {2'b10, 32'h0000_3000 + 32'(4 * i)}) begin
                miscompares++;
                $display("FAIL seq_fetch%0d: got req=%b valid=%b addr=%h want 1 0 %h",
                         i, im_req, if_valid, im_addr, 32'h0000_3000 + 32'(4 * i));
            end
            im_rdata = 32'hA000_0000 + 32'(i);
            tick();
            vectors++;
            if ({im_req, if_valid, if_instr, if_pc} !==
                {2'b01, 32'hA000_0000 + 32'(i), 32'h0000_3000 + 32'(4 * i)}) begin
                miscompares++;
                $display("FAIL seq_hold%0d: got req=%b valid=%b instr=%h pc=%h",
                         i, im_req, if_valid, if_instr, if_pc);
            end
            tick();
        end
        im_ack = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        im_ack = 1'b1; im_rdata = 32'hB1B1_0001;
        tick();
        im_ack = 1'b0; if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({im_req, if_valid, if_instr, if_pc} !== {2'b01, 32'hB1B1_0001, 32'h0000_3000}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got req=%b valid=%b instr=%h pc=%h",
                         i, im_req, if_valid, if_instr, if_pc);
            end
        end
        if_ready = 1'b1;
        tick();
        vectors++;
        if ({im_req, if_valid, im_addr} !== {2'b10, 32'h0000_3004}) begin
            miscompares++;
            $display("FAIL stall_release: got req=%b valid=%b addr=%h want 1 0 3004",
                     im_req, if_valid, im_addr);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        im_ack = 1'b1; im_rdata = 32'h1000_0040;
        tick(); tick();
        im_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_3100;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0000_3004}) begin
            miscompares++;
            $display("FAIL delay_slot_kept: got req=%b addr=%h want 1 3004", im_req, im_addr);
        end
        redirect = 1'b0; im_ack = 1'b1; im_rdata = 32'h0100_0000;
        tick();
        vectors++;
        if ({if_valid, if_instr, if_pc, pc} !== {1'b1, 32'h0100_0000, 32'h0000_3004, 32'h0000_3100}) begin
            miscompares++;
            $display("FAIL delay_slot_held: got valid=%b instr=%h if_pc=%h pc=%h",
                     if_valid, if_instr, if_pc, pc);
        end
        im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0000_3100}) begin
            miscompares++;
            $display("FAIL pending_target: got req=%b addr=%h want 1 3100", im_req, im_addr);
        end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        im_ack = 1'b1;
        tick(); tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_3200; im_rdata = 32'hC0C0_3008;
        tick();
        vectors++;
        if ({if_pc, pc} !== {32'h0000_3008, 32'h0000_3200}) begin
            miscompares++;
            $display("FAIL redirect_on_ack: got if_pc=%h pc=%h want 3008 3200", if_pc, pc);
        end
        redirect = 1'b0; im_ack = 1'b0;
        tick();
        im_ack = 1'b1;
        tick();
        vectors++;
        if (pc !== 32'h0000_3204) begin
            miscompares++;
            $display("FAIL pend_cleared: got pc=%h want 3204", pc);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_3400; im_ack = 1'b0;
        tick();
        redirect_pc = 32'h0000_3500;
        tick();
        redirect = 1'b0; im_ack = 1'b1;
        tick();
        vectors++;
        if ({if_pc, pc} !== {32'h0000_3204, 32'h0000_3500}) begin
            miscompares++;
            $display("FAIL latest_wins: got if_pc=%h pc=%h want 3204 3500", if_pc, pc);
        end
        im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0000_3500}) begin
            miscompares++;
            $display("FAIL latest_fetch: got req=%b addr=%h want 1 3500", im_req, im_addr);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h0000_3102;
        tick();
        vectors++;
        if (addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_err_set: got %b want 1", addr_err);
        end
        redirect = 1'b0; im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr, addr_err} !== {1'b1, 32'h0000_3100, 1'b1}) begin
            miscompares++;
            $display("FAIL misaligned_target: got req=%b addr=%h err=%b want 1 3100 1",
                     im_req, im_addr, addr_err);
        end
        im_ack = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_err_sticky: got %b want 1", addr_err);
        end
        reset = 1'b0; im_ack = 1'b0;
        tick();
        vectors++;
        if (addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL addr_err_reset: got %b want 0", addr_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        im_ack = 1'b1; im_rdata = 32'hE0E0_0001;
        tick(); tick();
        reset = 1'b0; im_rdata = 32'hE0E0_0002; redirect = 1'b1; redirect_pc = 32'h0000_3800;
        tick();
        vectors++;
        if ({im_req, if_valid, pc, if_instr} !== {2'b00, 32'h0000_3000, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: got req=%b valid=%b pc=%h instr=%h",
                     im_req, if_valid, pc, if_instr);
        end
        reset = 1'b1; redirect = 1'b0; im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0000_3000}) begin
            miscompares++;
            $display("FAIL refetch_after_reset: got req=%b addr=%h want 1 3000", im_req, im_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        im_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_fetch: got req=%b addr=%h want 1 fffffffc", im_req, im_addr);
        end
        im_ack = 1'b1; im_rdata = 32'hF00D_0000;
        tick();
        vectors++;
        if ({if_pc, pc} !== {32'hFFFF_FFFC, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_pc: got if_pc=%h pc=%h want fffffffc 0", if_pc, pc);
        end
        im_ack = 1'b0;
        tick();
        vectors++;
        if ({im_req, im_addr} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL wrap_next: got req=%b addr=%h want 1 0", im_req, im_addr);
        end
    endtask

    initial begin
        reset = 1'b0; im_ack = 1'b0; im_rdata = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; if_ready = 1'b1;
        test_reset();
        test_idle_redirect();
        test_sequential();
        test_stall();
        test_redirect_pending();
        test_redirect_with_ack();
        test_misaligned();
        test_reset_mid_fetch();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low (0 = reset), sampled on rising edge of clk only.
REQ-004 SHALL have port im_req  output  1  instruction-memory read request.
REQ-005 SHALL have port im_addr  output  32  word address of request; always equals pc.
REQ-006 SHALL have port im_ack  input  1  memory returns im_rdata this cycle; ignored when im_req=0.
REQ-007 SHALL have port im_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port redirect  input  1  ID-stage control transfer resolved (nPC result differs from sequential).
REQ-009 SHALL have port redirect_pc  input  32  target from nPC logic.
REQ-010 SHALL have port if_ready  input  1  IF/ID register accepts (driven as !stall by hazard unit).
REQ-011 SHALL have port if_valid  output  1  if_instr/if_pc hold a fetched instruction.
REQ-012 SHALL have port if_instr  output  32  held instruction.
REQ-013 SHALL have port if_pc  output  32  address of held instruction.
REQ-014 SHALL have port pc  output  32  current fetch address.
REQ-015 SHALL have port addr_err  output  1  sticky: a misaligned redirect_pc was received.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD; im_req=1 exactly in FETCH, if_valid=1 exactly in HOLD.
REQ-017 IDLE SHALL last one cycle after reset release, then go to FETCH.
REQ-018 FETCH with im_ack=1 SHALL capture if_instr<=im_rdata, if_pc<=pc, go to HOLD; im_ack=0 stays in FETCH, pc/im_addr stable.
REQ-019 On the im_ack cycle pc SHALL update to pend_pc if pend_valid (clearing pend_valid), else pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-020 HOLD with if_ready=1 SHALL go to FETCH next cycle; if_ready=0 SHALL hold state and all if_* outputs unchanged.
REQ-021 Minimum fetch rate SHALL be one instruction per 2 cycles (ack in cycle n -> if_valid in n+1 -> next im_req in n+2 at earliest).
REQ-022 redirect=1 SHALL set pend_valid<=1, pend_pc<={redirect_pc[31:2],2'b00} in any state except IDLE; ignored in IDLE.
REQ-023 The instruction currently in flight or held (branch delay slot) SHALL never be discarded by redirect; target applies to the following fetch.
REQ-024 redirect and im_ack in the same cycle SHALL make pc<=target directly; pend_valid ends 0.
REQ-025 A second redirect while pend_valid=1 SHALL overwrite pend_pc (latest wins).
REQ-026 redirect_pc[1:0]!=0 with redirect=1 SHALL set addr_err=1 until reset; target still low-bits-cleared.
REQ-027 im_addr SHALL always have bits [1:0]=2'b00.

Reset
REQ-028 reset=0 at a rising edge SHALL force: state IDLE, pc=RESET_PC, im_req=0, if_valid=0, if_instr=0, if_pc=0, pend_valid=0, pend_pc=0, addr_err=0.
REQ-029 Reset mid-FETCH or mid-HOLD SHALL abandon the request/held instruction; an im_ack in the reset cycle SHALL be ignored.
REQ-030 Reset SHALL take priority over redirect, im_ack and if_ready in the same cycle.

Verification
REQ-031 Reset, im_ack=1 always, if_ready=1 -> im_addr 0x3000, 0x3004, 0x3008 on alternate cycles; if_pc follows one cycle after each ack.
REQ-032 HOLD with if_ready=0 for 3 cycles -> if_valid=1, if_instr/if_pc constant, im_req=0; then if_ready=1 -> FETCH next cycle.
REQ-033 Branch fetched at 0x3000 in ID, redirect=1 redirect_pc=0x3100 while 0x3004 in FETCH with im_ack=0 -> 0x3004 still delivered, next im_addr=0x3100.
REQ-034 redirect (0x3200) same cycle as im_ack for 0x3008 -> pc=0x3200 next cycle, pend_valid=0; redirect 0x3400 then 0x3500 before ack -> next fetch 0x3500.
REQ-035 redirect_pc=0x3102 -> addr_err=1, next fetch 0x3100; addr_err stays 1 until reset=0.
REQ-036 reset=0 in FETCH with im_ack=1 -> if_valid=0, pc=0x3000, IDLE next cycle; pc at 32'hFFFF_FFFC acked -> pc=0.
